// File: rtl/scnn_pkg.sv
// Shared types and widths for the SCNN tile scheduler.
package scnn_pkg;

    localparam int unsigned IDX_W     = 8;
    localparam int unsigned LANES_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StReduce,
        StDone
    } sched_state_t;

endpackage

// File: rtl/scnn_tile_sched_if.sv
// Tile issue handshake between the scheduler (master) and the PE array (slave).
interface scnn_tile_sched_if #(
    parameter int unsigned LANES = scnn_pkg::LANES_DEF
);
    logic                       tile_valid;
    logic                       tile_ready;
    logic [scnn_pkg::IDX_W-1:0] ip_base;
    logic [scnn_pkg::IDX_W-1:0] wt_base;
    logic [LANES-1:0]           ip_mask;
    logic [LANES-1:0]           wt_mask;
    logic                       wt_first;
    logic                       tile_last;

    modport master (
        output tile_valid, ip_base, wt_base, ip_mask, wt_mask, wt_first, tile_last,
        input  tile_ready
    );

    modport slave (
        input  tile_valid, ip_base, wt_base, ip_mask, wt_mask, wt_first, tile_last,
        output tile_ready
    );
endinterface

// File: rtl/scnn_lane_mask.sv
// Per-lane occupancy mask: lane i is real when base + i < count.
module scnn_lane_mask
    import scnn_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic [IDX_W-1:0] base,
    input  logic [IDX_W-1:0] count,
    output logic [LANES-1:0] mask
);

    // One extra bit so base + i never wraps for counts up to 255.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign mask[i] = ({1'b0, base} + (IDX_W + 1)'(i)) < {1'b0, count};
    end

endmodule

// File: rtl/scnn_tile_sched.sv
// Cartesian-product tile scheduler: walks input x weight tiles, drains, reduces, signals done.
// Optional SCNN_SCHED_PERF_EN adds busy-cycle and stall counters.
module scnn_tile_sched
    import scnn_pkg::*;
#(
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [IDX_W-1:0]  num_nz_ips,
    input  logic [IDX_W-1:0]  num_nz_wts,
    scnn_tile_sched_if.master tile,
    output logic              reduce_en,
    output logic              busy,
    output logic              done
`ifdef SCNN_SCHED_PERF_EN
    ,
    output logic [15:0]       cyc_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [IDX_W:0] Step      = LANES[IDX_W:0];
    localparam logic [7:0]     DrainLast = 8'(DRAIN_CYC - 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] ips_q, ips_d, wts_q, wts_d;
    logic [IDX_W-1:0] ip_base_q, ip_base_d, wt_base_q, wt_base_d;
    logic [7:0]       drain_q, drain_d;
    logic [IDX_W:0]   ip_next, wt_next;
    logic             wt_wrap, ip_wrap, issue, hs;
    logic [LANES-1:0] ip_mask, wt_mask;

    assign ip_next = {1'b0, ip_base_q} + Step;
    assign wt_next = {1'b0, wt_base_q} + Step;
    assign wt_wrap = wt_next >= {1'b0, wts_q};
    assign ip_wrap = ip_next >= {1'b0, ips_q};
    assign issue   = (state_q == StIssue);
    assign busy    = (state_q != StIdle);

    // flush masks the offer in the same cycle so no handshake can slip through.
    assign tile.tile_valid = issue && !flush;
    assign tile.ip_base    = ip_base_q;
    assign tile.wt_base    = wt_base_q;
    assign tile.ip_mask    = ip_mask;
    assign tile.wt_mask    = wt_mask;
    assign tile.wt_first   = issue && (wt_base_q == '0);
    assign tile.tile_last  = issue && wt_wrap && ip_wrap;
    assign hs              = tile.tile_valid && tile.tile_ready;

    scnn_lane_mask #(.LANES(LANES)) u_ip_mask (
        .base  (ip_base_q),
        .count (ips_q),
        .mask  (ip_mask)
    );

    scnn_lane_mask #(.LANES(LANES)) u_wt_mask (
        .base  (wt_base_q),
        .count (wts_q),
        .mask  (wt_mask)
    );

    always_comb begin
        state_d   = state_q;
        ips_d     = ips_q;
        wts_d     = wts_q;
        ip_base_d = ip_base_q;
        wt_base_d = wt_base_q;
        drain_d   = drain_q;
        reduce_en = 1'b0;
        done      = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ips_d     = num_nz_ips;
                        wts_d     = num_nz_wts;
                        ip_base_d = '0;
                        wt_base_d = '0;
                        state_d   = (num_nz_ips == '0 || num_nz_wts == '0) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    if (hs) begin
                        // Bases are left on the final tile; the next start clears them.
                        if (tile.tile_last) begin
                            state_d = StDrain;
                            drain_d = '0;
                        end else if (wt_wrap) begin
                            wt_base_d = '0;
                            ip_base_d = ip_next[IDX_W-1:0];
                        end else begin
                            wt_base_d = wt_next[IDX_W-1:0];
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == DrainLast) state_d = StReduce;
                    else                      drain_d = drain_q + 8'd1;
                end
                StReduce: begin
                    reduce_en = 1'b1;
                    state_d   = StDone;
                end
                StDone: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ips_q     <= '0;
            wts_q     <= '0;
            ip_base_q <= '0;
            wt_base_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            ips_q     <= ips_d;
            wts_q     <= wts_d;
            ip_base_q <= ip_base_d;
            wt_base_q <= wt_base_d;
            drain_q   <= drain_d;
        end
    end

`ifdef SCNN_SCHED_PERF_EN
    logic [15:0] cyc_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (state_q == StIdle && start && !flush) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (busy && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
            if (tile.tile_valid && !tile.tile_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
`endif

endmodule
